// File: rtl/pipe_stage_chain.sv
// Parametrised inter-stage pipeline buffer: DEPTH stages of {valid, WIDTH payload}.
// Supports indexed stall with bubble insertion, indexed flush, forwarding taps,
// and debug counters for occupancy and retired entries.
module pipe_stage_chain #(
  parameter int          WIDTH       = 64,
  parameter int          DEPTH       = 4,
  parameter int          IDX_W       = 2,
  // Reset value of the retired counter; nonzero only for wrap-around checks.
  parameter logic [31:0] RETIRED_RST = 32'd0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  input  logic                   stall_en,
  input  logic [IDX_W-1:0]       stall_idx,
  input  logic                   flush_en,
  input  logic [IDX_W-1:0]       flush_idx,
  output logic [DEPTH-1:0]       stage_valid,
  output logic [DEPTH*WIDTH-1:0] stage_data,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [IDX_W:0]         occupancy,
  output logic [31:0]            retired
);

  // Elaboration-time sanity checks on the geometry.
  if (DEPTH < 2) begin : g_depth_chk
    $error("pipe_stage_chain: DEPTH must be at least 2");
  end
  if ((1 << IDX_W) < DEPTH) begin : g_idx_chk
    $error("pipe_stage_chain: IDX_W too narrow to address every stage");
  end

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [WIDTH-1:0] dat_d [DEPTH];
  logic [IDX_W:0]   occ_q;
  logic [IDX_W:0]   occ_d;
  logic [31:0]      ret_q;

  int   stall_pos;
  int   flush_pos;
  logic stall_act;
  logic out_frozen;

  // Clamp the stage indices and decide whether the stall is live (flush wins).
  always_comb begin
    stall_pos  = (int'(stall_idx) > DEPTH - 1) ? DEPTH - 1 : int'(stall_idx);
    flush_pos  = (int'(flush_idx) > DEPTH - 1) ? DEPTH - 1 : int'(flush_idx);
    stall_act  = stall_en & ~flush_en;
    out_frozen = stall_act & (stall_pos == DEPTH - 1);
  end

  // Next-state of every stage: default shift, then flush or stall overrides.
  always_comb begin
    vld_d    = {vld_q[DEPTH-2:0], in_valid};
    dat_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      dat_d[i] = dat_q[i-1];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (flush_en) begin
        // Killed stages and the stage just past them all become bubbles.
        if (i <= flush_pos + 1) begin
          vld_d[i] = 1'b0;
          dat_d[i] = '0;
        end
      end else if (stall_act) begin
        if (i <= stall_pos) begin
          vld_d[i] = vld_q[i];
          dat_d[i] = dat_q[i];
        end else if (i == stall_pos + 1) begin
          vld_d[i] = 1'b0;
          dat_d[i] = '0;
        end
      end
    end
  end

  // Occupancy is the popcount of the next valid vector so it tracks stage_valid.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + {{IDX_W{1'b0}}, vld_d[i]};
    end
  end

  // Stage registers and occupancy; reset overrides stall and flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      occ_q <= occ_d;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  // Retired counter: counts valid entries leaving the last stage, wraps freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      ret_q <= RETIRED_RST;
    end else if (vld_q[DEPTH-1] && !out_frozen) begin
      ret_q <= ret_q + 32'd1;
    end
  end

  // Flatten the per-stage payloads onto the forwarding tap bus.
  always_comb begin
    stage_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      stage_data[i*WIDTH +: WIDTH] = dat_q[i];
    end
  end

  assign in_ready    = ~stall_en | flush_en;
  assign stage_valid = vld_q;
  assign out_valid   = vld_q[DEPTH-1];
  assign out_data    = dat_q[DEPTH-1];
  assign occupancy   = occ_q;
  assign retired     = ret_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain (WIDTH=8, DEPTH=4, IDX_W=3).
// A second instance with a near-wrap retired reset value checks counter wrap.
module tb_pipe_stage_chain;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        stall_en;
  logic [2:0]  stall_idx;
  logic        flush_en;
  logic [2:0]  flush_idx;
  logic [3:0]  stage_valid;
  logic [31:0] stage_data;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [3:0]  occupancy;
  logic [31:0] retired;

  logic        w_in_ready;
  logic [3:0]  w_stage_valid;
  logic [31:0] w_stage_data;
  logic        w_out_valid;
  logic [7:0]  w_out_data;
  logic [3:0]  w_occupancy;
  logic [31:0] w_retired;

  int total = 0;
  int bad   = 0;

  pipe_stage_chain #(.WIDTH(8), .DEPTH(4), .IDX_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .stall_en(stall_en), .stall_idx(stall_idx), .flush_en(flush_en), .flush_idx(flush_idx),
    .stage_valid(stage_valid), .stage_data(stage_data), .out_valid(out_valid),
    .out_data(out_data), .occupancy(occupancy), .retired(retired)
  );

  pipe_stage_chain #(.WIDTH(8), .DEPTH(4), .IDX_W(3), .RETIRED_RST(32'hFFFF_FFFE)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(w_in_ready),
    .stall_en(stall_en), .stall_idx(stall_idx), .flush_en(flush_en), .flush_idx(flush_idx),
    .stage_valid(w_stage_valid), .stage_data(w_stage_data), .out_valid(w_out_valid),
    .out_data(w_out_data), .occupancy(w_occupancy), .retired(w_retired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    in_valid  = 1'b0;
    in_data   = 8'h00;
    stall_en  = 1'b0;
    stall_idx = 3'd0;
    flush_en  = 1'b0;
    flush_idx = 3'd0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Loads 11,22,33,44 so the chain reads s0..s3 = 44,33,22,11.
  task automatic fill();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h11 * (k + 1));
      step();
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_valid", stage_valid, 4'h0);
    chk("rst_data", stage_data, 32'h0);
    chk("rst_occ", occupancy, 4'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_wrap_retired", w_retired, 32'hFFFF_FFFE);

    // Fill with latency check: out_valid only on the 4th edge
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h11 * (k + 1));
      step();
      if (k < 3) chk("lat_out_valid_early", out_valid, 1'b0);
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    chk("fill_out_valid", out_valid, 1'b1);
    chk("fill_out_data", out_data, 8'h11);
    chk("fill_data", stage_data, 32'h1122_3344);
    chk("fill_valid", stage_valid, 4'hF);
    chk("fill_occ", occupancy, 4'd4);
    chk("fill_retired", retired, 32'd0);

    // Stall at stage 1 with bubble into stage 2
    stall_en  = 1'b1;
    stall_idx = 3'd1;
    in_valid  = 1'b1;
    in_data   = 8'h99;
    #1;
    chk("stall_in_ready", in_ready, 1'b0);
    step();
    chk("stall_data", stage_data, 32'h2200_3344);
    chk("stall_valid", stage_valid, 4'b1011);
    chk("stall_occ", occupancy, 4'd3);
    chk("stall_retired", retired, 32'd1);
    clear_in();

    // Flush from stage 0: s0,s1 bubbles, input dropped
    do_reset();
    fill();
    flush_en  = 1'b1;
    flush_idx = 3'd0;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    #1;
    chk("flush_in_ready", in_ready, 1'b1);
    step();
    chk("flush_data", stage_data, 32'h2233_0000);
    chk("flush_valid", stage_valid, 4'b1100);
    chk("flush_occ", occupancy, 4'd2);
    chk("flush_retired", retired, 32'd1);
    clear_in();

    // Flush and stall together at index 3: flush wins, everything bubbles
    do_reset();
    fill();
    flush_en  = 1'b1;
    flush_idx = 3'd3;
    stall_en  = 1'b1;
    stall_idx = 3'd3;
    in_valid  = 1'b1;
    in_data   = 8'h66;
    #1;
    chk("both_in_ready", in_ready, 1'b1);
    step();
    chk("both_data", stage_data, 32'h0);
    chk("both_valid", stage_valid, 4'h0);
    chk("both_occ", occupancy, 4'd0);
    chk("both_retired", retired, 32'd1);
    clear_in();

    // Full freeze with stall_idx 3, then clamped stall_idx 7
    do_reset();
    fill();
    stall_en  = 1'b1;
    stall_idx = 3'd3;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("freeze3_data", stage_data, 32'h1122_3344);
      chk("freeze3_retired", retired, 32'd0);
    end
    stall_idx = 3'd7;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("freeze7_data", stage_data, 32'h1122_3344);
      chk("freeze7_retired", retired, 32'd0);
    end
    chk("freeze7_occ", occupancy, 4'd4);
    chk("freeze7_in_ready", in_ready, 1'b0);

    // Release: normal advance with an invalid input
    clear_in();
    step();
    chk("release_data", stage_data, 32'h2233_4400);
    chk("release_valid", stage_valid, 4'b1110);
    chk("release_retired", retired, 32'd1);
    chk("release_occ", occupancy, 4'd3);

    // Flush from stage 1: s0..s2 bubbles, s3 takes old s2
    flush_en  = 1'b1;
    flush_idx = 3'd1;
    step();
    chk("flush1_data", stage_data, 32'h3300_0000);
    chk("flush1_valid", stage_valid, 4'b1000);
    chk("flush1_occ", occupancy, 4'd1);
    chk("flush1_retired", retired, 32'd2);

    // Clamped flush index 7 kills everything, old s3 still retires
    flush_idx = 3'd7;
    step();
    chk("flush7_valid", stage_valid, 4'h0);
    chk("flush7_occ", occupancy, 4'd0);
    chk("flush7_retired", retired, 32'd3);
    clear_in();

    // Stall at stage 2: last stage gets a bubble, old s3 retires once
    do_reset();
    fill();
    stall_en  = 1'b1;
    stall_idx = 3'd2;
    step();
    chk("stall2_data", stage_data, 32'h0022_3344);
    chk("stall2_valid", stage_valid, 4'b0111);
    chk("stall2_occ", occupancy, 4'd3);
    chk("stall2_retired", retired, 32'd1);
    step();
    chk("stall2_bubble_no_retire", retired, 32'd1);
    clear_in();

    // Reset while stalled and full
    do_reset();
    fill();
    in_valid = 1'b1;
    in_data  = 8'h55;
    step();
    chk("pre_rst_data", stage_data, 32'h2233_4455);
    chk("pre_rst_retired", retired, 32'd1);
    in_valid  = 1'b0;
    in_data   = 8'h00;
    stall_en  = 1'b1;
    stall_idx = 3'd3;
    rst       = 1'b1;
    step();
    rst = 1'b0;
    clear_in();
    chk("midrst_data", stage_data, 32'h0);
    chk("midrst_valid", stage_valid, 4'h0);
    chk("midrst_occ", occupancy, 4'd0);
    chk("midrst_retired", retired, 32'd0);
    chk("midrst_wrap_retired", w_retired, 32'hFFFF_FFFE);

    // Retired counter wrap on the near-wrap instance
    fill();
    chk("wrap_pre", w_retired, 32'hFFFF_FFFE);
    step();
    chk("wrap_max", w_retired, 32'hFFFF_FFFF);
    step();
    chk("wrap_zero", w_retired, 32'h0000_0000);
    chk("wrap_main_retired", retired, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised replacement for the fixed fetch/decode/execute/memory inter-stage buffers.
- DEPTH register stages carry a WIDTH-bit payload plus a valid bit.
- Supports indexed stall with bubble insertion and indexed flush, both driven by the hazard and branch logic.
- Provides per-stage taps for the forwarding unit, plus occupancy and retired-instruction counters for debug.

Parameters:
- WIDTH, 64, payload bits per stage.
- DEPTH, 4, number of stages (≥2); stage 0 is youngest, stage DEPTH-1 is the output.
- IDX_W, 2, width of stage-index ports; must be ≥ clog2(DEPTH).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  new entry offered to stage 0.
- in_data  in  WIDTH  payload for stage 0.
- in_ready  out  1  entry accepted this cycle; combinational, equals !stall_en | flush_en.
- stall_en  in  1  stall request.
- stall_idx  in  IDX_W  oldest stage to freeze.
- flush_en  in  1  flush request.
- flush_idx  in  IDX_W  oldest stage whose content is killed.
- stage_valid  out  DEPTH  valid bit of each stage.
- stage_data  out  DEPTH*WIDTH  flattened payloads; stage i occupies bits [i*WIDTH +: WIDTH].
- out_valid  out  1  equals stage_valid[DEPTH-1].
- out_data  out  WIDTH  equals stage DEPTH-1 payload.
- occupancy  out  IDX_W+1  count of valid stages; registered, always equal to popcount(stage_valid).
- retired  out  32  count of valid entries that have left stage DEPTH-1.

Behaviour:
- Reset (rst=1 at an edge):
  - All stage_valid=0, all stage_data=0, occupancy=0, retired=0.
  - Reset overrides stall and flush.
- Bubble definition: valid=0, data=0.
- Normal advance (no stall, no flush):
  - next[0] = {in_valid, in_data}.
  - next[i] = cur[i-1] for i≥1.
  - Stage DEPTH-1 content leaves the chain.
- Stall (stall_en=1, flush_en=0). Let s = min(stall_idx, DEPTH-1).
  - Stages 0..s hold their contents.
  - Stage s+1 (if it exists) loads a bubble.
  - Stages > s+1 advance normally.
  - in_ready=0; the input is not captured.
  - s = DEPTH-1 freezes the whole chain; nothing leaves.
- Flush (flush_en=1). Let f = min(flush_idx, DEPTH-1).
  - Stages 0..min(f+1, DEPTH-1) load bubbles.
  - Stages > f+1 advance normally.
  - The input is discarded, but in_ready=1.
  - Flush wins over a simultaneous stall: stall_en is ignored entirely that cycle.
- No bypass: latency input→out_valid is exactly DEPTH cycles when unstalled.
- Out-of-range stall_idx or flush_idx are clamped as above. No error output.
- retired:
  - Increments by 1 at an edge where out_valid=1 and stage DEPTH-1 is not frozen.
  - A flush never freezes stage DEPTH-1.
  - Wraps 0xFFFFFFFF→0.
- occupancy is updated on the same edge as stage_valid and always matches it.
- Bubbles never increment retired.
- A frozen valid entry is never duplicated or lost.

Test Plan (WIDTH=8, DEPTH=4):
- Reset/fill:
  - rst 1 cycle → all outputs 0.
  - Then in_valid=1 with data 0x11, 0x22, 0x33, 0x44 on consecutive cycles → out_data=0x11 with out_valid=1 on the 4th edge after 0x11 is applied; occupancy=4; retired=0.
- Stall with bubble:
  - Full chain [s0..s3]=44,33,22,11.
  - stall_en=1, stall_idx=1 for 1 cycle → s0=44, s1=33 held; s2=bubble; s3=22; retired=1; in_ready=0 during the stall.
- Flush:
  - Full chain 44,33,22,11; flush_en=1, flush_idx=0, in_data=0x55 → s0, s1 become bubbles; s2=33, s3=22; 0x55 dropped; occupancy=2.
- Simultaneous events:
  - flush_en=1 with flush_idx=3, plus stall_en=1 with stall_idx=3 → all stages bubbles; retired increments once (for the old s3); stall ignored.
- Full freeze and clamp:
  - stall_idx=3 for 5 cycles → contents unchanged; retired constant.
  - Then stall_idx=7 with IDX_W=3 → same freeze behaviour (clamped).
- Counter wrap and reset mid-operation:
  - Force retired to 0xFFFFFFFF via a long run, then retire one entry → retired=0.
  - Assert rst while stalled and full → next edge all-zero state.
